// File: rtl/ff_pipe_pkg.sv
// Shared helpers for the elastic register pipeline.
// Only the occupancy-width function lives here.
package ff_pipe_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ff_pipe_if.sv
// Producer/consumer handshake bundle for ff_pipe.
// master drives stimulus and consumes; slave is the pipeline.
interface ff_pipe_if
    import ff_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = cnt_w(DEPTH);

    logic             flush;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_d;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_q;
    logic [CW-1:0]    occupancy;

    modport master (
        output flush, in_vld, in_d, out_rdy,
        input  in_rdy, out_vld, out_q, occupancy
    );

    modport slave (
        input  flush, in_vld, in_d, out_rdy,
        output in_rdy, out_vld, out_q, occupancy
    );

endinterface

// File: rtl/ff_pipe_stage.sv
// One elastic stage: valid bit plus data register.
// Accepts when empty or when downstream drains this cycle.
module ff_pipe_stage
    import ff_pipe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_h,
    input  logic             flush,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_d,
    input  logic             dn_rdy,
    output logic             vld,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);
    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;

    assign rdy = !vld_q || dn_rdy;
    assign vld = vld_q;
    assign d   = d_q;

    // Next state: flush beats load, load beats drain; data moves only on load.
    always_comb begin
        vld_d = vld_q;
        d_d   = d_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (up_vld && rdy) begin
            vld_d = 1'b1;
            d_d   = up_d;
        end else if (dn_rdy) begin
            vld_d = 1'b0;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_h) begin
            vld_q <= 1'b0;
            d_q   <= RST_VAL;
        end else begin
            vld_q <= vld_d;
            d_q   <= d_d;
        end
    end

endmodule

// File: rtl/ff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready ends.
// Chains stages, counts valid stages, drives the bus outputs.
module ff_pipe
    import ff_pipe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic     clk,
    input  logic     rst_h,
    ff_pipe_if.slave bus
);
    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [CW-1:0]    occ;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_d;
        logic             dn_rdy;
        logic             rdy_o;

        if (i == 0) begin : g_head
            assign up_vld = bus.in_vld;
            assign up_d   = bus.in_d;
        end else begin : g_body
            assign up_vld = vld[i-1];
            assign up_d   = dat[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_rdy = bus.out_rdy;
        end else begin : g_mid
            assign dn_rdy = g_stage[i+1].rdy_o;
        end

        ff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk    (clk),
            .rst_h  (rst_h),
            .flush  (bus.flush),
            .up_vld (up_vld),
            .up_d   (up_d),
            .dn_rdy (dn_rdy),
            .vld    (vld[i]),
            .d      (dat[i]),
            .rdy    (rdy_o)
        );
    end

    // Popcount of stage valid bits; bounded by DEPTH so never wraps.
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + CW'(vld[k]);
        end
    end

    assign bus.in_rdy    = g_stage[0].rdy_o && !bus.flush;
    assign bus.out_vld   = vld[DEPTH-1];
    assign bus.out_q     = dat[DEPTH-1];
    assign bus.occupancy = occ;

endmodule

// File: tb/tb_ff_pipe.sv
// Directed table-driven bench for ff_pipe at DEPTH=4 and DEPTH=1.
// Each row gives one cycle of inputs and the outputs expected before its edge.
module tb_ff_pipe;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_q;
        logic [2:0] e_occ;
    } vec_t;

    logic clk;
    logic rst_h;

    int n_cmp;
    int n_bad;

    vec_t tab4[$];
    vec_t tab1[$];

    ff_pipe_if #(.WIDTH(8), .DEPTH(4)) b4 ();
    ff_pipe_if #(.WIDTH(8), .DEPTH(1)) b1 ();

    ff_pipe #(
        .WIDTH   (8),
        .DEPTH   (4),
        .RST_VAL (8'hA5)
    ) dut4 (
        .clk   (clk),
        .rst_h (rst_h),
        .bus   (b4)
    );

    ff_pipe #(
        .WIDTH   (8),
        .DEPTH   (1),
        .RST_VAL (8'hA5)
    ) dut1 (
        .clk   (clk),
        .rst_h (rst_h),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input bit sel, input logic r, input logic f,
                       input logic iv, input logic [7:0] id,
                       input logic ordy, input logic er, input logic ev,
                       input logic [7:0] eq, input logic [2:0] eo);
        vec_t v;
        v.rst   = r;
        v.fl    = f;
        v.iv    = iv;
        v.id    = id;
        v.ordy  = ordy;
        v.e_rdy = er;
        v.e_vld = ev;
        v.e_q   = eq;
        v.e_occ = eo;
        if (sel) tab1.push_back(v);
        else     tab4.push_back(v);
    endtask

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h, expected %0h",
                     name, row, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v, input bit sel, input int row);
        rst_h = v.rst;
        if (sel) begin
            b1.flush   = v.fl;
            b1.in_vld  = v.iv;
            b1.in_d    = v.id;
            b1.out_rdy = v.ordy;
        end else begin
            b4.flush   = v.fl;
            b4.in_vld  = v.iv;
            b4.in_d    = v.id;
            b4.out_rdy = v.ordy;
        end
        #1;
        if (sel) begin
            check("d1_in_rdy", row, 32'(b1.in_rdy), 32'(v.e_rdy));
            check("d1_out_vld", row, 32'(b1.out_vld), 32'(v.e_vld));
            check("d1_out_q", row, 32'(b1.out_q), 32'(v.e_q));
            check("d1_occ", row, 32'(b1.occupancy), 32'(v.e_occ));
        end else begin
            check("d4_in_rdy", row, 32'(b4.in_rdy), 32'(v.e_rdy));
            check("d4_out_vld", row, 32'(b4.out_vld), 32'(v.e_vld));
            check("d4_out_q", row, 32'(b4.out_q), 32'(v.e_q));
            check("d4_occ", row, 32'(b4.occupancy), 32'(v.e_occ));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Streaming 01..08, out_rdy=1
        add(0, 0, 0, 1, 8'h01, 1, 1, 0, 8'hA5, 0);
        add(0, 0, 0, 1, 8'h02, 1, 1, 0, 8'hA5, 1);
        add(0, 0, 0, 1, 8'h03, 1, 1, 0, 8'hA5, 2);
        add(0, 0, 0, 1, 8'h04, 1, 1, 0, 8'hA5, 3);
        add(0, 0, 0, 1, 8'h05, 1, 1, 1, 8'h01, 4);
        add(0, 0, 0, 1, 8'h06, 1, 1, 1, 8'h02, 4);
        add(0, 0, 0, 1, 8'h07, 1, 1, 1, 8'h03, 4);
        add(0, 0, 0, 1, 8'h08, 1, 1, 1, 8'h04, 4);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h05, 4);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h06, 3);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h07, 2);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h08, 1);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h08, 0);
        // Stall with out_rdy=0, then release
        add(0, 0, 0, 1, 8'h10, 0, 1, 0, 8'h08, 0);
        add(0, 0, 0, 1, 8'h11, 0, 1, 0, 8'h08, 1);
        add(0, 0, 0, 1, 8'h12, 0, 1, 0, 8'h08, 2);
        add(0, 0, 0, 1, 8'h13, 0, 1, 0, 8'h08, 3);
        add(0, 0, 0, 1, 8'h14, 0, 0, 1, 8'h10, 4);
        add(0, 0, 0, 1, 8'h14, 0, 0, 1, 8'h10, 4);
        add(0, 0, 0, 1, 8'h14, 1, 1, 1, 8'h10, 4);
        add(0, 0, 0, 1, 8'h15, 1, 1, 1, 8'h11, 4);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h12, 4);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h13, 3);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h14, 2);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h15, 1);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h15, 0);
        // Bubble collapse under stall
        add(0, 0, 0, 1, 8'h20, 0, 1, 0, 8'h15, 0);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h15, 1);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h15, 1);
        add(0, 0, 0, 1, 8'h21, 0, 1, 0, 8'h15, 1);
        add(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h20, 2);
        add(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h20, 2);
        add(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h20, 2);
        add(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h20, 2);
        // Fill to full, then simultaneous in/out
        add(0, 0, 0, 1, 8'h22, 0, 1, 1, 8'h20, 2);
        add(0, 0, 0, 1, 8'h23, 0, 1, 1, 8'h20, 3);
        add(0, 0, 0, 1, 8'h24, 0, 0, 1, 8'h20, 4);
        add(0, 0, 0, 1, 8'h24, 1, 1, 1, 8'h20, 4);
        add(0, 0, 0, 1, 8'h25, 1, 1, 1, 8'h21, 4);
        add(0, 0, 0, 1, 8'h26, 1, 1, 1, 8'h22, 4);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h23, 4);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h24, 3);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h25, 2);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h26, 1);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h26, 0);
        // Flush with 3 in flight; input that cycle dropped
        add(0, 0, 0, 1, 8'h30, 0, 1, 0, 8'h26, 0);
        add(0, 0, 0, 1, 8'h31, 0, 1, 0, 8'h26, 1);
        add(0, 0, 0, 1, 8'h32, 0, 1, 0, 8'h26, 2);
        add(0, 0, 1, 1, 8'h33, 0, 0, 0, 8'h26, 3);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h26, 0);
        // Flush while the last stage hands out its word
        add(0, 0, 0, 1, 8'h40, 1, 1, 0, 8'h26, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h26, 1);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h26, 1);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h26, 1);
        add(0, 0, 1, 1, 8'h41, 1, 0, 1, 8'h40, 1);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h40, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h40, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h40, 0);
        // Reset together with flush mid-stream
        add(0, 0, 0, 1, 8'h50, 0, 1, 0, 8'h40, 0);
        add(0, 0, 0, 1, 8'h51, 0, 1, 0, 8'h40, 1);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 2);
        add(0, 1, 1, 1, 8'h52, 1, 0, 0, 8'h40, 2);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 0);

        // DEPTH=1: streaming then stall
        add(1, 0, 0, 1, 8'h01, 1, 1, 0, 8'hA5, 0);
        add(1, 0, 0, 1, 8'h02, 1, 1, 1, 8'h01, 1);
        add(1, 0, 0, 1, 8'h03, 1, 1, 1, 8'h02, 1);
        add(1, 0, 0, 1, 8'h04, 1, 1, 1, 8'h03, 1);
        add(1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h04, 1);
        add(1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h04, 0);
        add(1, 0, 0, 1, 8'h10, 0, 1, 0, 8'h04, 0);
        add(1, 0, 0, 1, 8'h11, 0, 0, 1, 8'h10, 1);
        add(1, 0, 0, 1, 8'h11, 0, 0, 1, 8'h10, 1);
        add(1, 0, 0, 1, 8'h11, 1, 1, 1, 8'h10, 1);
        add(1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h11, 1);
        add(1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h11, 0);

        rst_h      = 1'b1;
        b4.flush   = 1'b0;
        b4.in_vld  = 1'b0;
        b4.in_d    = 8'h00;
        b4.out_rdy = 1'b0;
        b1.flush   = 1'b0;
        b1.in_vld  = 1'b0;
        b1.in_d    = 8'h00;
        b1.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_h = 1'b0;

        for (int i = 0; i < tab4.size(); i++) run_row(tab4[i], 1'b0, i);

        b4.in_vld  = 1'b0;
        b4.out_rdy = 1'b0;
        b4.flush   = 1'b0;

        for (int i = 0; i < tab1.size(); i++) run_row(tab1[i], 1'b1, i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
